// File: rtl/cond_exec_stage.sv
// rtl/cond_exec_stage.sv - execute-stage pipeline register with condition-gated controls and flag register
//
// Purpose: holds the decode-stage controls for the instruction in execute, checks
// its condition field against the stored NZCV flags, suppresses writes and
// branches that fail the condition, and updates the flags from the ALU.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   StallE, FlushE      hold / bubble the execute register (FlushE wins)
//   PCSD .. NoWriteD    decode-stage control bits
//   FlagWD[1:0]         flag-write enables: bit1 = N,Z; bit0 = C,V
//   ALUControlD[4:0]    ALU operation select
//   CondD[3:0]          instruction condition field
//   ALUFlags[3:0]       {N,Z,C,V} produced for the instruction held in E
//   ALUControlE, ALUSrcE, MemtoRegE   registered pass-through
//   RegWriteE, MemWriteE, PCSrcE, BranchTakenE, CondExE   condition-gated controls
//   Flags[3:0]          architectural {N,Z,C,V}
module cond_exec_stage (
  input  logic       clk,
  input  logic       reset,
  input  logic       StallE,
  input  logic       FlushE,
  input  logic       PCSD,
  input  logic       RegWD,
  input  logic       MemWD,
  input  logic       MemtoRegD,
  input  logic       ALUSrcD,
  input  logic       BranchD,
  input  logic       NoWriteD,
  input  logic [1:0] FlagWD,
  input  logic [4:0] ALUControlD,
  input  logic [3:0] CondD,
  input  logic [3:0] ALUFlags,
  output logic [4:0] ALUControlE,
  output logic       ALUSrcE,
  output logic       MemtoRegE,
  output logic       RegWriteE,
  output logic       MemWriteE,
  output logic       PCSrcE,
  output logic       BranchTakenE,
  output logic       CondExE,
  output logic [3:0] Flags
);

  logic       pcs_e;
  logic       regw_e;
  logic       memw_e;
  logic       memtoreg_e;
  logic       alusrc_e;
  logic       branch_e;
  logic       nowrite_e;
  logic [1:0] flagw_e;
  logic [4:0] alucontrol_e;
  logic [3:0] cond_e;

  // Execute register: flush inserts an all-zero bubble even when stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcs_e        <= 1'b0;
      regw_e       <= 1'b0;
      memw_e       <= 1'b0;
      memtoreg_e   <= 1'b0;
      alusrc_e     <= 1'b0;
      branch_e     <= 1'b0;
      nowrite_e    <= 1'b0;
      flagw_e      <= 2'b00;
      alucontrol_e <= 5'd0;
      cond_e       <= 4'd0;
    end else if (FlushE) begin
      pcs_e        <= 1'b0;
      regw_e       <= 1'b0;
      memw_e       <= 1'b0;
      memtoreg_e   <= 1'b0;
      alusrc_e     <= 1'b0;
      branch_e     <= 1'b0;
      nowrite_e    <= 1'b0;
      flagw_e      <= 2'b00;
      alucontrol_e <= 5'd0;
      cond_e       <= 4'd0;
    end else if (!StallE) begin
      pcs_e        <= PCSD;
      regw_e       <= RegWD;
      memw_e       <= MemWD;
      memtoreg_e   <= MemtoRegD;
      alusrc_e     <= ALUSrcD;
      branch_e     <= BranchD;
      nowrite_e    <= NoWriteD;
      flagw_e      <= FlagWD;
      alucontrol_e <= ALUControlD;
      cond_e       <= CondD;
    end
  end

  // Condition check uses the stored flags, i.e. the state left by older
  // instructions, never the flags this instruction is producing.
  logic flag_n, flag_z, flag_c, flag_v;
  assign {flag_n, flag_z, flag_c, flag_v} = Flags;

  always_comb begin
    CondExE = 1'b0;
    unique case (cond_e)
      4'b0000: CondExE = flag_z;
      4'b0001: CondExE = ~flag_z;
      4'b0010: CondExE = flag_c;
      4'b0011: CondExE = ~flag_c;
      4'b0100: CondExE = flag_n;
      4'b0101: CondExE = ~flag_n;
      4'b0110: CondExE = flag_v;
      4'b0111: CondExE = ~flag_v;
      4'b1000: CondExE = flag_c & ~flag_z;
      4'b1001: CondExE = ~flag_c | flag_z;
      4'b1010: CondExE = (flag_n == flag_v);
      4'b1011: CondExE = (flag_n != flag_v);
      4'b1100: CondExE = ~flag_z & (flag_n == flag_v);
      4'b1101: CondExE = flag_z | (flag_n != flag_v);
      default: CondExE = 1'b1;
    endcase
  end

  assign ALUControlE  = alucontrol_e;
  assign ALUSrcE      = alusrc_e;
  assign MemtoRegE    = memtoreg_e;
  assign RegWriteE    = regw_e & CondExE & ~nowrite_e;
  assign MemWriteE    = memw_e & CondExE;
  assign BranchTakenE = branch_e & CondExE;
  assign PCSrcE       = (pcs_e | branch_e) & CondExE;

  // Flags commit only on the edge where the instruction leaves E, so a stalled
  // instruction cannot write them more than once.
  logic upd_nz, upd_cv;
  assign upd_nz = flagw_e[1] & CondExE & ~StallE;
  assign upd_cv = flagw_e[0] & CondExE & ~StallE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Flags <= 4'b0000;
    end else begin
      if (upd_nz) Flags[3:2] <= ALUFlags[3:2];
      if (upd_cv) Flags[1:0] <= ALUFlags[1:0];
    end
  end

endmodule

// File: doc/cond_exec_stage.md
COND_EXEC_STAGE -- requirements
Module: cond_exec_stage

Interface
REQ-001 The module SHALL use one clock and an asynchronous active-low reset; no other clock or reset exists.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-low reset.
REQ-004 StallE  input  1  hold execute-stage register contents.
REQ-005 FlushE  input  1  load a bubble (all-zero control) into the execute stage.
REQ-006 PCSD, RegWD, MemWD, MemtoRegD, ALUSrcD, BranchD, NoWriteD  input  1 each  decode-stage control bits.
REQ-007 FlagWD  input  2  flag-write enables: bit1 = N,Z; bit0 = C,V.
REQ-008 ALUControlD  input  5  ALU operation select, passed through unchanged.
REQ-009 CondD  input  4  instruction condition field [31:28].
REQ-010 ALUFlags  input  4  {N,Z,C,V} from the execute-stage ALU for the instruction currently held in E.
REQ-011 ALUControlE  output  5;  ALUSrcE, MemtoRegE  output  1 each: registered pass-through.
REQ-012 RegWriteE, MemWriteE, PCSrcE, BranchTakenE, CondExE  output  1 each: condition-gated controls.
REQ-013 Flags  output  4  architectural {N,Z,C,V} register.

Function
REQ-014 E register set = {PCS, RegW, MemW, MemtoReg, ALUSrc, Branch, NoWrite, FlagW, ALUControl, Cond}, captured at the rising clk edge.
REQ-015 Edge priority: FlushE=1 -> all E fields 0 (FlushE wins over StallE); else StallE=1 -> hold; else load the D inputs.
REQ-016 Latency: D inputs appear on E outputs one clk after capture; gated outputs are combinational from E fields and Flags.
REQ-017 CondExE SHALL be evaluated from Flags (the stored register), not from ALUFlags.
REQ-018 Condition table: 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V; 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 1.
REQ-019 RegWriteE = RegW_E & CondExE & ~NoWrite_E.
REQ-020 MemWriteE = MemW_E & CondExE.
REQ-021 BranchTakenE = Branch_E & CondExE; PCSrcE = (PCS_E | Branch_E) & CondExE.
REQ-022 Flags[3:2] SHALL load ALUFlags[3:2] at the edge iff FlagW_E[1] & CondExE & ~StallE.
REQ-023 Flags[1:0] SHALL load ALUFlags[1:0] at the edge iff FlagW_E[0] & CondExE & ~StallE.
REQ-024 During a stall, flags SHALL NOT update, so an instruction held in E writes flags exactly once, at the edge where it leaves E.
REQ-025 A flushed bubble (all-zero E) SHALL assert no write, branch, or flag-update output; Cond=0000 is then don't-care because all enables are 0.
REQ-026 Flags is unaffected by FlushE/StallE on the D side; only REQ-022/023 modify it.

Reset
REQ-027 reset=0 SHALL immediately, without waiting for a clk edge, clear every E field and Flags to 0; every output then reads 0 except CondExE, which follows REQ-018 for Cond=0000, Z=0 (CondExE=0).
REQ-028 Reset asserted mid-stall or mid-flush SHALL override both; the first load after release occurs at the first clk edge with reset=1.

Verification
REQ-029 Reset mid-op: RegWD=1, CondD=1110 loaded, then reset=0 between edges -> RegWriteE=0 and Flags=0000 within the same cycle.
REQ-030 CMP/BEQ: load FlagWD=11, NoWriteD=1, RegWD=1, CondD=1110, ALUFlags=0100 -> RegWriteE=0; next edge Flags=0100; load BranchD=1, CondD=0000 -> BranchTakenE=1, PCSrcE=1.
REQ-031 Condition fail: Flags=0000, load CondD=0000, RegWD=1, MemWD=1, FlagWD=11, ALUFlags=1111 -> RegWriteE=0, MemWriteE=0; Flags stays 0000 after the edge.
REQ-032 Stall: E holds FlagW=11, CondExE=1, ALUFlags=1000 with StallE=1 for 2 edges -> E outputs unchanged, Flags unchanged; StallE=0 edge -> Flags=1000.
REQ-033 Flush+stall on the same edge -> all E outputs 0 after the edge; Flags unchanged.
REQ-034 Signed compares: Flags=1001 (N=1, V=1, Z=0), CondD=1100 -> CondExE=1; CondD=1101 -> 0; CondD=1011 -> 0.
